// File: rtl/alu_exec_if.sv
// alu_exec_if
// Request/response bundle between an ALU execution unit and its producer/consumer.
//   in_valid/in_ready         : request handshake (producer -> ALU)
//   control_signal, op_a, op_b: operation code and operands, captured on accept
//   out_valid/out_ready       : result handshake (ALU -> consumer)
//   result, zero, illegal     : registered result and its status flags
// Modports: master = producer/consumer side (e.g. a testbench), slave = the ALU.
interface alu_exec_if #(
  parameter int XLEN = 32
);
  logic            in_valid;
  logic            in_ready;
  logic [3:0]      control_signal;
  logic [XLEN-1:0] op_a;
  logic [XLEN-1:0] op_b;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] result;
  logic            zero;
  logic            illegal;

  modport master (
    output in_valid, control_signal, op_a, op_b, out_ready,
    input  in_ready, out_valid, result, zero, illegal
  );

  modport slave (
    input  in_valid, control_signal, op_a, op_b, out_ready,
    output in_ready, out_valid, result, zero, illegal
  );
endinterface

// File: rtl/alu_exec.sv
// alu_exec
// Handshaked ALU execution stage. A request is captured when in_valid && in_ready;
// the result and its zero/illegal flags are registered and held until the consumer
// takes them with out_valid && out_ready. A retire and a new accept may share one
// edge, so a continuous stream runs without bubbles.
// Ports:
//   clk    : single clock, rising edge
//   rst_n  : asynchronous active-low reset
//   bus    : alu_exec_if.slave (request, operands, result and handshakes)
// Operation codes: 0000 AND, 0001 OR, 0010 ADD, 0110 SUB, 0100 signed LT,
//   0101 signed GE; anything else returns 0 with zero=1 and illegal=1.
// Optional feature, macro ALU_EXEC_SHIFT_EN: adds 0011 SLL and 0111 SRL, shifted
//   one bit per cycle from a BUSY state. Shift amount is op_b[log2(XLEN)-1:0].
//   Without the macro those codes are illegal and no shift hardware exists.
module alu_exec #(
  parameter int XLEN = 32
) (
  input  logic      clk,
  input  logic      rst_n,
  alu_exec_if.slave bus
);

  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_OR  = 4'b0001;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_SUB = 4'b0110;
  localparam logic [3:0] OP_SLT = 4'b0100;
  localparam logic [3:0] OP_SGE = 4'b0101;
`ifdef ALU_EXEC_SHIFT_EN
  localparam logic [3:0] OP_SLL = 4'b0011;
  localparam logic [3:0] OP_SRL = 4'b0111;
  localparam int         SHW    = (XLEN > 1) ? $clog2(XLEN) : 1;
`endif

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic [XLEN-1:0] result_q, result_d;
  logic            zero_q, zero_d;
  logic            illegal_q, illegal_d;

  logic            accept;
  logic [XLEN-1:0] alu_res;
  logic            alu_illegal;

`ifdef ALU_EXEC_SHIFT_EN
  logic [SHW-1:0]  cnt_q, cnt_d;
  logic            dir_q, dir_d;
  logic            is_shift;
  logic [SHW-1:0]  shamt;
  logic            start_shift;

  // Only a nonzero shift amount needs the iterative path; a zero amount
  // completes like any single-cycle op with op_a passed through.
  assign is_shift    = (bus.control_signal == OP_SLL) || (bus.control_signal == OP_SRL);
  assign shamt       = bus.op_b[SHW-1:0];
  assign start_shift = is_shift && (shamt != '0);
`endif

  // A slot opens when idle, or when the held result is being retired this edge.
  assign bus.in_ready  = (state_q == IDLE) || ((state_q == DONE) && bus.out_ready);
  assign accept        = bus.in_valid && bus.in_ready;
  assign bus.out_valid = (state_q == DONE);
  assign bus.result    = result_q;
  assign bus.zero      = zero_q;
  assign bus.illegal   = illegal_q;

  // Single-cycle datapath evaluated on the live request inputs.
  always_comb begin
    alu_res     = '0;
    alu_illegal = 1'b0;
    unique case (bus.control_signal)
      OP_AND:  alu_res = bus.op_a & bus.op_b;
      OP_OR:   alu_res = bus.op_a | bus.op_b;
      OP_ADD:  alu_res = bus.op_a + bus.op_b;
      OP_SUB:  alu_res = bus.op_a - bus.op_b;
      OP_SLT:  alu_res[0] = $signed(bus.op_a) < $signed(bus.op_b);
      OP_SGE:  alu_res[0] = $signed(bus.op_a) >= $signed(bus.op_b);
`ifdef ALU_EXEC_SHIFT_EN
      OP_SLL,
      OP_SRL:  alu_res = bus.op_a;
`endif
      default: alu_illegal = 1'b1;
    endcase
  end

  // Next-state logic: accept/retire in IDLE/DONE, one shift step per cycle in BUSY.
  always_comb begin
    state_d   = state_q;
    result_d  = result_q;
    zero_d    = zero_q;
    illegal_d = illegal_q;
`ifdef ALU_EXEC_SHIFT_EN
    cnt_d     = cnt_q;
    dir_d     = dir_q;
`endif
    unique case (state_q)
`ifdef ALU_EXEC_SHIFT_EN
      BUSY: begin
        result_d = dir_q ? (result_q >> 1) : (result_q << 1);
        cnt_d    = cnt_q - 1'b1;
        if (cnt_q == SHW'(1)) begin
          state_d = DONE;
          zero_d  = (result_d == '0);
        end
      end
`endif
      default: begin
        if ((state_q == DONE) && bus.out_ready) begin
          state_d = IDLE;
        end
        if (accept) begin
          state_d   = DONE;
          result_d  = alu_res;
          zero_d    = (alu_res == '0);
          illegal_d = alu_illegal;
`ifdef ALU_EXEC_SHIFT_EN
          if (start_shift) begin
            state_d   = BUSY;
            result_d  = bus.op_a;
            zero_d    = 1'b0;
            illegal_d = 1'b0;
            cnt_d     = shamt;
            dir_d     = (bus.control_signal == OP_SRL);
          end
`endif
        end
      end
    endcase
  end

  // State and result registers; reset discards any pending or in-flight op.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      result_q  <= '0;
      zero_q    <= 1'b0;
      illegal_q <= 1'b0;
`ifdef ALU_EXEC_SHIFT_EN
      cnt_q     <= '0;
      dir_q     <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      result_q  <= result_d;
      zero_q    <= zero_d;
      illegal_q <= illegal_d;
`ifdef ALU_EXEC_SHIFT_EN
      cnt_q     <= cnt_d;
      dir_q     <= dir_d;
`endif
    end
  end

endmodule

// File: tb/tb_alu_exec.sv
// tb_alu_exec
// Directed self-checking bench for alu_exec. Inputs are driven and outputs
// sampled on the falling clock edge; the DUT acts on the rising edge.
// Shift expectations follow ALU_EXEC_SHIFT_EN when it is defined.
module tb_alu_exec;

  logic clk;
  logic rst_n;
  int   passCount;
  int   checkCount;

  alu_exec_if #(.XLEN(32)) bus ();

  alu_exec #(.XLEN(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // 10 ns clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Hard time limit so the bench can never hang.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  // Drive one request at a falling edge, drop in_valid at the next falling edge.
  task automatic applyStimulus(input logic [3:0] code, input logic [31:0] a, input logic [31:0] b);
    bus.control_signal = code;
    bus.op_a           = a;
    bus.op_b           = b;
    bus.in_valid       = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst_n              = 1'b0;
    bus.in_valid       = 1'b0;
    bus.out_ready      = 1'b1;
    bus.control_signal = 4'b0000;
    bus.op_a           = '0;
    bus.op_b           = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checkCount++; if (bus.out_valid !== 1'b0) $display("[TB] FAIL reset_out_valid got=%b want=0", bus.out_valid); else passCount++;
    checkCount++; if (bus.in_ready !== 1'b1) $display("[TB] FAIL reset_in_ready got=%b want=1", bus.in_ready); else passCount++;
    checkCount++; if (bus.result !== 32'h0) $display("[TB] FAIL reset_result got=%h want=0", bus.result); else passCount++;
    checkCount++; if (bus.zero !== 1'b0) $display("[TB] FAIL reset_zero got=%b want=0", bus.zero); else passCount++;
    checkCount++; if (bus.illegal !== 1'b0) $display("[TB] FAIL reset_illegal got=%b want=0", bus.illegal); else passCount++;
  endtask

  task automatic test_add();
    bus.out_ready = 1'b1;
    applyStimulus(4'b0010, 32'h5, 32'h3);
    checkCount++; if (bus.out_valid !== 1'b1) $display("[TB] FAIL add_out_valid got=%b want=1", bus.out_valid); else passCount++;
    checkCount++; if (bus.result !== 32'h8) $display("[TB] FAIL add_result got=%h want=00000008", bus.result); else passCount++;
    checkCount++; if (bus.zero !== 1'b0) $display("[TB] FAIL add_zero got=%b want=0", bus.zero); else passCount++;
    checkCount++; if (bus.illegal !== 1'b0) $display("[TB] FAIL add_illegal got=%b want=0", bus.illegal); else passCount++;
    @(negedge clk);
    checkCount++; if (bus.out_valid !== 1'b0) $display("[TB] FAIL add_retired got=%b want=0", bus.out_valid); else passCount++;
    applyStimulus(4'b0010, 32'hFFFF_FFFF, 32'h1);
    checkCount++; if (bus.result !== 32'h0) $display("[TB] FAIL add_wrap_result got=%h want=0", bus.result); else passCount++;
    checkCount++; if (bus.zero !== 1'b1) $display("[TB] FAIL add_wrap_zero got=%b want=1", bus.zero); else passCount++;
    @(negedge clk);
  endtask

  task automatic test_compare();
    bus.out_ready = 1'b1;
    applyStimulus(4'b0110, 32'h1234_5678, 32'h1234_5678);
    checkCount++; if (bus.result !== 32'h0) $display("[TB] FAIL sub_result got=%h want=0", bus.result); else passCount++;
    checkCount++; if (bus.zero !== 1'b1) $display("[TB] FAIL sub_zero got=%b want=1", bus.zero); else passCount++;
    @(negedge clk);
    applyStimulus(4'b0100, 32'hFFFF_FFFF, 32'h1);
    checkCount++; if (bus.result !== 32'h1) $display("[TB] FAIL slt_result got=%h want=00000001", bus.result); else passCount++;
    checkCount++; if (bus.zero !== 1'b0) $display("[TB] FAIL slt_zero got=%b want=0", bus.zero); else passCount++;
    @(negedge clk);
    applyStimulus(4'b0101, 32'hFFFF_FFFF, 32'h1);
    checkCount++; if (bus.result !== 32'h0) $display("[TB] FAIL sge_result got=%h want=0", bus.result); else passCount++;
    checkCount++; if (bus.zero !== 1'b1) $display("[TB] FAIL sge_zero got=%b want=1", bus.zero); else passCount++;
    @(negedge clk);
    applyStimulus(4'b0110, 32'h0000_0003, 32'h0000_0005);
    checkCount++; if (bus.result !== 32'hFFFF_FFFE) $display("[TB] FAIL sub_wrap_result got=%h want=fffffffe", bus.result); else passCount++;
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    bus.out_ready      = 1'b1;
    bus.control_signal = 4'b0000;
    bus.op_a           = 32'hF0F0_F0F0;
    bus.op_b           = 32'hFF00_FF00;
    bus.in_valid       = 1'b1;
    @(negedge clk);
    checkCount++; if (bus.out_valid !== 1'b1) $display("[TB] FAIL b2b_and_valid got=%b want=1", bus.out_valid); else passCount++;
    checkCount++; if (bus.result !== 32'hF000_F000) $display("[TB] FAIL b2b_and_result got=%h want=f000f000", bus.result); else passCount++;
    checkCount++; if (bus.in_ready !== 1'b1) $display("[TB] FAIL b2b_in_ready got=%b want=1", bus.in_ready); else passCount++;
    bus.control_signal = 4'b0001;
    @(negedge clk);
    bus.in_valid = 1'b0;
    checkCount++; if (bus.out_valid !== 1'b1) $display("[TB] FAIL b2b_or_valid got=%b want=1", bus.out_valid); else passCount++;
    checkCount++; if (bus.result !== 32'hFFF0_FFF0) $display("[TB] FAIL b2b_or_result got=%h want=fff0fff0", bus.result); else passCount++;
    @(negedge clk);
    checkCount++; if (bus.out_valid !== 1'b0) $display("[TB] FAIL b2b_drained got=%b want=0", bus.out_valid); else passCount++;
  endtask

  task automatic test_backpressure();
    bus.out_ready = 1'b0;
    applyStimulus(4'b0010, 32'h1, 32'h1);
    // A competing request is offered while stalled; it must be ignored.
    bus.control_signal = 4'b0010;
    bus.op_a           = 32'h7;
    bus.op_b           = 32'h7;
    bus.in_valid       = 1'b1;
    for (int i = 0; i < 5; i++) begin
      checkCount++; if (bus.out_valid !== 1'b1) $display("[TB] FAIL bp_valid[%0d] got=%b want=1", i, bus.out_valid); else passCount++;
      checkCount++; if (bus.result !== 32'h2) $display("[TB] FAIL bp_result[%0d] got=%h want=00000002", i, bus.result); else passCount++;
      checkCount++; if (bus.in_ready !== 1'b0) $display("[TB] FAIL bp_in_ready[%0d] got=%b want=0", i, bus.in_ready); else passCount++;
      @(negedge clk);
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(negedge clk);
    checkCount++; if (bus.out_valid !== 1'b0) $display("[TB] FAIL bp_retire got=%b want=0", bus.out_valid); else passCount++;
    checkCount++; if (bus.result !== 32'h2) $display("[TB] FAIL bp_no_extra_accept got=%h want=00000002", bus.result); else passCount++;
  endtask

  task automatic test_illegal_shift();
    int n;
    bus.out_ready = 1'b1;
    applyStimulus(4'b1111, 32'hDEAD_BEEF, 32'h1234_5678);
    checkCount++; if (bus.result !== 32'h0) $display("[TB] FAIL illegal_result got=%h want=0", bus.result); else passCount++;
    checkCount++; if (bus.zero !== 1'b1) $display("[TB] FAIL illegal_zero got=%b want=1", bus.zero); else passCount++;
    checkCount++; if (bus.illegal !== 1'b1) $display("[TB] FAIL illegal_flag got=%b want=1", bus.illegal); else passCount++;
    @(negedge clk);

    // SLL 1 by 4: count falling edges from the accept edge to out_valid.
    bus.control_signal = 4'b0011;
    bus.op_a           = 32'h1;
    bus.op_b           = 32'h4;
    bus.in_valid       = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      bus.in_valid = 1'b0;
      n++;
    end while (!bus.out_valid && n < 20);
`ifdef ALU_EXEC_SHIFT_EN
    checkCount++; if (n !== 5) $display("[TB] FAIL sll_latency got=%0d want=5", n); else passCount++;
    checkCount++; if (bus.result !== 32'h10) $display("[TB] FAIL sll_result got=%h want=00000010", bus.result); else passCount++;
    checkCount++; if (bus.illegal !== 1'b0) $display("[TB] FAIL sll_illegal got=%b want=0", bus.illegal); else passCount++;
    @(negedge clk);
    applyStimulus(4'b0111, 32'h8000_0000, 32'h4);
    checkCount++; if (bus.in_ready !== 1'b0) $display("[TB] FAIL srl_busy_in_ready got=%b want=0", bus.in_ready); else passCount++;
    n = 1;
    while (!bus.out_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    checkCount++; if (n !== 5) $display("[TB] FAIL srl_latency got=%0d want=5", n); else passCount++;
    checkCount++; if (bus.result !== 32'h0800_0000) $display("[TB] FAIL srl_result got=%h want=08000000", bus.result); else passCount++;
    @(negedge clk);
    applyStimulus(4'b0011, 32'hABCD_0123, 32'h0);
    checkCount++; if (bus.out_valid !== 1'b1) $display("[TB] FAIL sll0_latency got=%b want=1", bus.out_valid); else passCount++;
    checkCount++; if (bus.result !== 32'hABCD_0123) $display("[TB] FAIL sll0_result got=%h want=abcd0123", bus.result); else passCount++;
`else
    checkCount++; if (n !== 1) $display("[TB] FAIL sll_disabled_latency got=%0d want=1", n); else passCount++;
    checkCount++; if (bus.illegal !== 1'b1) $display("[TB] FAIL sll_disabled_illegal got=%b want=1", bus.illegal); else passCount++;
    checkCount++; if (bus.result !== 32'h0) $display("[TB] FAIL sll_disabled_result got=%h want=0", bus.result); else passCount++;
`endif
    @(negedge clk);
  endtask

  task automatic test_reset_busy();
    int staleSeen;
    bus.out_ready = 1'b0;
    applyStimulus(4'b0111, 32'h8000_0000, 32'd31);
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    checkCount++; if (bus.out_valid !== 1'b0) $display("[TB] FAIL rstbusy_valid got=%b want=0", bus.out_valid); else passCount++;
    checkCount++; if (bus.result !== 32'h0) $display("[TB] FAIL rstbusy_result got=%h want=0", bus.result); else passCount++;
    rst_n         = 1'b1;
    bus.out_ready = 1'b1;
    @(negedge clk);
    checkCount++; if (bus.in_ready !== 1'b1) $display("[TB] FAIL rstbusy_in_ready got=%b want=1", bus.in_ready); else passCount++;
    checkCount++; if (bus.illegal !== 1'b0) $display("[TB] FAIL rstbusy_illegal got=%b want=0", bus.illegal); else passCount++;
    staleSeen = 0;
    for (int i = 0; i < 40; i++) begin
      if (bus.out_valid !== 1'b0 || bus.result !== 32'h0) staleSeen++;
      @(negedge clk);
    end
    checkCount++; if (staleSeen !== 0) $display("[TB] FAIL rstbusy_stale got=%0d cycles want=0", staleSeen); else passCount++;
  endtask

  initial begin
    passCount  = 0;
    checkCount = 0;
    test_reset();
    test_add();
    test_compare();
    test_back_to_back();
    test_backpressure();
    test_illegal_shift();
    test_reset_busy();
    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule

// File: doc/alu_exec.md
ALU_EXEC -- requirements
Module: alu_exec

Interface
REQ-001 Parameter: XLEN, default 32, operand and result width in bits.
REQ-002 clk  input  1  single clock; all state on rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 in_valid  input  1  operation request valid.
REQ-005 in_ready  output  1  block can accept a request this cycle.
REQ-006 control_signal  input  4  ALU operation code from ALU control decoder.
REQ-007 op_a  input  XLEN  operand A (rs1).
REQ-008 op_b  input  XLEN  operand B (rs2 or immediate).
REQ-009 out_valid  output  1  result valid.
REQ-010 out_ready  input  1  consumer accepts result.
REQ-011 result  output  XLEN  operation result.
REQ-012 zero  output  1  result == 0.
REQ-013 illegal  output  1  accepted code was unsupported.

Function
REQ-014 Request accepted on a rising edge where in_valid && in_ready; control_signal, op_a, op_b captured at that edge.
REQ-015 Codes: 0000 AND; 0001 OR; 0010 ADD (mod 2^XLEN); 0110 SUB (op_a - op_b, mod 2^XLEN); 0100 signed less-than, result = {0..., a<b}; 0101 signed greater-or-equal, result = {0..., a>=b}.
REQ-016 Any other code (subject to REQ-027): result = 0, zero = 1, illegal = 1; still handshaken normally.
REQ-017 States: IDLE, BUSY, DONE.
REQ-018 IDLE: in_ready = 1, out_valid = 0; on accept of a single-cycle op -> DONE; on accept of shift op with shamt != 0 -> BUSY.
REQ-019 Single-cycle op latency: accepted at edge N, out_valid = 1 after edge N+1... i.e. visible in the cycle following edge N.
REQ-020 DONE: out_valid = 1; result, zero, illegal held stable until out_valid && out_ready edge.
REQ-021 DONE and out_ready = 1: in_ready = 1; simultaneous output retire and new accept at same edge -> DONE/BUSY per new op, no bubble.
REQ-022 DONE and out_ready = 0: in_ready = 0; in_valid ignored.
REQ-023 BUSY: in_ready = 0, out_valid = 0; shift counter decrements one per cycle; -> DONE when counter reaches 0.
REQ-024 zero and illegal are registered with result, never combinational on inputs.
REQ-025 Inputs other than clk/rst_n are don't-care when not being captured.

Reset
REQ-026 rst_n low, any state (incl. BUSY mid-shift, DONE unretired): state = IDLE, out_valid = 0, result = 0, zero = 0, illegal = 0, shift counter = 0, in_ready = 1 after release; pending operation discarded.

Configuration
REQ-027 Macro ALU_EXEC_SHIFT_EN defined: codes 0011 SLL and 0111 SRL (logical) supported; shamt = op_b[log2(XLEN)-1:0]; executed iteratively one bit position per cycle; shamt = 0 behaves as single-cycle op; shamt = k > 0 gives out_valid k+1 cycles after accept edge.
REQ-028 Macro ALU_EXEC_SHIFT_EN undefined: 0011 and 0111 are illegal per REQ-016; BUSY state unreachable and shift logic absent.

Verification
REQ-029 Reset, then ADD a=0x00000005 b=0x00000003, out_ready=1 -> out_valid next cycle, result=0x00000008, zero=0, illegal=0.
REQ-030 SUB a=b=0x12345678 -> result=0, zero=1; code 0100 a=0xFFFFFFFF b=0x00000001 -> result=1; code 0101 same operands -> result=0, zero=1.
REQ-031 Back-to-back: AND 0xF0F0F0F0,0xFF00FF00 then OR same operands, in_valid and out_ready held high -> results 0xF000F000 then 0xFFF0FFF0 on consecutive cycles, no bubble.
REQ-032 Backpressure: ADD 1+1 with out_ready=0 for 5 cycles -> out_valid and result=2 held, in_ready=0 throughout; retire on out_ready=1.
REQ-033 Code 1111 -> result=0, zero=1, illegal=1; with ALU_EXEC_SHIFT_EN, SLL a=0x1 b=4 -> out_valid 5 cycles after accept, result=0x10; without macro, same stimulus -> illegal=1 next cycle.
REQ-034 Assert rst_n low during BUSY (SRL a=0x80000000 b=31, 3 cycles in) -> out_valid=0, result=0, in_ready=1 after release; no stale result emitted.
